// File: rtl/axis_packet_buffer.sv
// Store-and-forward AXI4-Stream packet FIFO: buffers tlast-framed packets and
// releases only complete ones; packets that cannot fit are dropped whole and counted.
module axis_packet_buffer #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int ADDR_WIDTH       = 10
) (
  input  logic                        aclk,
  input  logic                        areset,
  output logic [31:0]                 sts_drop,
  output logic [ADDR_WIDTH-1:0]       sts_level,
  output logic                        s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        s_axis_tlast,
  input  logic                        m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int WW    = AXIS_TDATA_WIDTH + 1;

  typedef logic [ADDR_WIDTH-1:0] ptr_t;
  typedef enum logic [1:0] {SYNC, PASS, DROP} state_e;

  state_e                      state_q;
  ptr_t                        wr_ptr_q, cm_ptr_q, rd_ptr_q;
  ptr_t                        wr_ptr_d, cm_ptr_d, rd_ptr_d;
  ptr_t                        level_q;
  logic [31:0]                 drop_q;
  logic [WW-1:0]               mem [DEPTH];
  logic [WW-1:0]               rd_data_q;
  logic                        pf_valid_q;
  logic                        m_valid_q, m_last_q;
  logic [AXIS_TDATA_WIDTH-1:0] m_data_q;

  logic accept, full, wr_en, overflow, out_load, rd_en;

  assign s_axis_tready = ~areset;

  always_comb begin
    accept   = s_axis_tvalid && !areset;
    full     = (wr_ptr_q + ptr_t'(1)) == rd_ptr_q;
    wr_en    = accept && (state_q == PASS) && !full;
    overflow = accept && (state_q == PASS) && full;

    cm_ptr_d = cm_ptr_q;
    if (wr_en && s_axis_tlast) cm_ptr_d = wr_ptr_q + ptr_t'(1);

    wr_ptr_d = wr_ptr_q;
    if (wr_en)         wr_ptr_d = wr_ptr_q + ptr_t'(1);
    else if (overflow) wr_ptr_d = cm_ptr_q;

    // Prefetch refills whenever it is empty or is handing its word to the output register.
    out_load = pf_valid_q && (!m_valid_q || m_axis_tready);
    rd_en    = (rd_ptr_q != cm_ptr_q) && (!pf_valid_q || out_load);
    rd_ptr_d = rd_en ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= SYNC;
      wr_ptr_q   <= '0;
      cm_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      drop_q     <= '0;
      pf_valid_q <= 1'b0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      m_data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      cm_ptr_q <= cm_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= cm_ptr_d - rd_ptr_d;

      case (state_q)
        SYNC: if (accept && s_axis_tlast) state_q <= PASS;
        PASS: if (overflow) begin
          drop_q <= drop_q + 32'd1;
          if (!s_axis_tlast) state_q <= DROP;
        end
        DROP: if (accept && s_axis_tlast) state_q <= PASS;
        default: state_q <= SYNC;
      endcase

      if (rd_en)         pf_valid_q <= 1'b1;
      else if (out_load) pf_valid_q <= 1'b0;

      if (out_load) begin
        m_valid_q <= 1'b1;
        m_data_q  <= rd_data_q[AXIS_TDATA_WIDTH-1:0];
        m_last_q  <= rd_data_q[AXIS_TDATA_WIDTH];
      end else if (m_axis_tready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  // NOTE: the storage array and its read register carry no reset; validity is
  // tracked by the pointers and pf_valid_q, so this maps onto plain block RAM.
  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_ptr_q] <= {s_axis_tlast, s_axis_tdata};
    if (rd_en) rd_data_q <= mem[rd_ptr_q];
  end

  assign sts_drop      = drop_q;
  assign sts_level     = level_q;
  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tlast  = m_last_q;

endmodule

// File: tb/tb_axis_packet_buffer.sv
// Directed bench for axis_packet_buffer with a 16-deep buffer (capacity 15 words).
module tb_axis_packet_buffer;

  localparam int W  = 32;
  localparam int AW = 4;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic [31:0]   sts_drop;
  logic [AW-1:0] sts_level;
  logic          s_axis_tready;
  logic [W-1:0]  s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          m_axis_tready = 1'b1;
  logic [W-1:0]  m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;

  int checks = 0;
  int failures = 0;
  logic [W:0] got [$];
  logic [W:0] exp_q [$];

  axis_packet_buffer #(.AXIS_TDATA_WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .aclk(aclk), .areset(areset), .sts_drop(sts_drop), .sts_level(sts_level),
    .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast)
  );

  always #5 aclk = ~aclk;

  // Outputs are sampled mid-cycle; a valid&ready seen here completes on the next rising edge.
  always @(negedge aclk)
    if (!areset && m_axis_tvalid && m_axis_tready) got.push_back({m_axis_tlast, m_axis_tdata});

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected to finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send_pkt(input logic [W-1:0] base, input int len);
    for (int i = 0; i < len; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = base + W'(i);
      s_axis_tlast  = (i == len - 1);
      tick();
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  // After reset the input sits in SYNC, so a lone tlast beat aligns it to a packet boundary.
  task automatic do_reset();
    s_axis_tvalid = 1'b0;
    areset = 1'b1;
    repeat (2) tick();
    areset = 1'b0;
    send_pkt(32'hDEAD_0000, 1);
    repeat (4) tick();
    got.delete();
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (2) tick();
    @(negedge aclk);
    checks++;
    if (s_axis_tready !== 1'b0) begin failures++; $display("FAIL reset_tready: got %b expected 0", s_axis_tready); end
    tick();
    areset = 1'b0;
    tick();
    @(negedge aclk);
    checks++;
    if ({s_axis_tready, m_axis_tvalid, m_axis_tlast} !== 3'b100) begin
      failures++; $display("FAIL reset_flags: got tready/tvalid/tlast=%b expected 100", {s_axis_tready, m_axis_tvalid, m_axis_tlast});
    end
    checks++;
    if (m_axis_tdata !== '0 || sts_drop !== '0 || sts_level !== '0) begin
      failures++; $display("FAIL reset_values: got tdata=%h drop=%0d level=%0d expected 0/0/0", m_axis_tdata, sts_drop, sts_level);
    end
    // Packet tail in flight at reset is swallowed by SYNC and never counted.
    send_pkt(32'h0000_0BAD, 2);
    repeat (6) tick();
    checks++;
    if (got.size() != 0 || sts_drop !== 32'd0 || sts_level !== '0) begin
      failures++; $display("FAIL sync_discard: got out=%0d drop=%0d level=%0d expected 0/0/0", got.size(), sts_drop, sts_level);
    end
    got.delete();
  endtask

  task automatic test_single();
    do_reset();
    m_axis_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 32'h10 + W'(i);
      s_axis_tlast  = (i == 3);
      tick();
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    @(negedge aclk);
    checks++;
    if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL lat_T0: got tvalid=%b expected 0", m_axis_tvalid); end
    tick();
    @(negedge aclk);
    checks++;
    if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL lat_T1: got tvalid=%b expected 0", m_axis_tvalid); end
    tick();
    @(negedge aclk);
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h10) begin
      failures++; $display("FAIL lat_T2: got tvalid=%b tdata=%h expected 1/00000010", m_axis_tvalid, m_axis_tdata);
    end
    repeat (8) tick();
    checks++;
    if (got.size() != 4) begin failures++; $display("FAIL single_count: got %0d expected 4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      logic [W:0] e;
      e = {(i == 3) ? 1'b1 : 1'b0, 32'h10 + W'(i)};
      checks++;
      if (got[i] !== e) begin failures++; $display("FAIL single_word%0d: got %h expected %h", i, got[i], e); end
    end
    checks++;
    if (sts_drop !== 32'd0) begin failures++; $display("FAIL single_drop: got %0d expected 0", sts_drop); end
  endtask

  task automatic test_overflow();
    do_reset();
    m_axis_tready = 1'b0;
    send_pkt(32'h100, 10);
    @(negedge aclk);
    checks++;
    if (sts_level !== AW'(10)) begin failures++; $display("FAIL ovf_level_commit: got %0d expected 10", sts_level); end
    send_pkt(32'h200, 8);
    repeat (4) tick();
    @(negedge aclk);
    checks++;
    if (sts_drop !== 32'd1) begin failures++; $display("FAIL ovf_drop: got %0d expected 1", sts_drop); end
    // Two words sit in the prefetch and output registers and no longer count as stored.
    checks++;
    if (sts_level !== AW'(8)) begin failures++; $display("FAIL ovf_level_held: got %0d expected 8", sts_level); end
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h100) begin
      failures++; $display("FAIL ovf_head: got tvalid=%b tdata=%h expected 1/00000100", m_axis_tvalid, m_axis_tdata);
    end
    tick();
    m_axis_tready = 1'b1;
    repeat (20) tick();
    checks++;
    if (got.size() != 10) begin failures++; $display("FAIL ovf_count: got %0d expected 10", got.size()); end
    for (int i = 0; i < 10 && i < got.size(); i++) begin
      logic [W:0] e;
      e = {(i == 9) ? 1'b1 : 1'b0, 32'h100 + W'(i)};
      checks++;
      if (got[i] !== e) begin failures++; $display("FAIL ovf_word%0d: got %h expected %h", i, got[i], e); end
    end
    checks++;
    if (sts_level !== '0) begin failures++; $display("FAIL ovf_level_end: got %0d expected 0", sts_level); end
  endtask

  task automatic test_oversize();
    do_reset();
    m_axis_tready = 1'b1;
    send_pkt(32'h300, 20);
    repeat (10) tick();
    checks++;
    if (sts_drop !== 32'd1 || sts_level !== '0 || got.size() != 0) begin
      failures++; $display("FAIL oversize: got drop=%0d level=%0d out=%0d expected 1/0/0", sts_drop, sts_level, got.size());
    end
    send_pkt(32'h380, 2);
    repeat (8) tick();
    checks++;
    if (got.size() != 2 || got[0] !== {1'b0, 32'h380} || got[got.size()-1] !== {1'b1, 32'h381}) begin
      failures++; $display("FAIL oversize_recover: got %0d words expected 380,381(last)", got.size());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_axis_tready = 1'b1;
    send_pkt(32'h500, 10);
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_axis_tdata = 32'h400 + W'(i);
      tick();
    end
    s_axis_tvalid = 1'b0;
    areset = 1'b1;
    tick();
    areset = 1'b0;
    got.delete();
    send_pkt(32'h403, 3);
    send_pkt(32'h600, 2);
    repeat (8) tick();
    checks++;
    if (got.size() != 2) begin failures++; $display("FAIL rstmid_count: got %0d expected 2", got.size()); end
    for (int i = 0; i < 2 && i < got.size(); i++) begin
      logic [W:0] e;
      e = {(i == 1) ? 1'b1 : 1'b0, 32'h600 + W'(i)};
      checks++;
      if (got[i] !== e) begin failures++; $display("FAIL rstmid_word%0d: got %h expected %h", i, got[i], e); end
    end
    checks++;
    if (sts_drop !== 32'd0) begin failures++; $display("FAIL rstmid_drop: got %0d expected 0", sts_drop); end
  endtask

  task automatic test_back_to_back();
    logic [W:0] prev;
    bit         prev_stall;
    do_reset();
    prev_stall = 1'b0;
    prev = '0;
    fork
      begin
        send_pkt(32'h700, 3);
        send_pkt(32'h710, 3);
      end
      for (int i = 0; i < 30; i++) begin
        m_axis_tready = (i % 2 == 0);
        @(negedge aclk);
        if (prev_stall) begin
          checks++;
          if (m_axis_tvalid !== 1'b1 || {m_axis_tlast, m_axis_tdata} !== prev) begin
            failures++; $display("FAIL b2b_stall_hold: got %b/%h expected 1/%h", m_axis_tvalid, {m_axis_tlast, m_axis_tdata}, prev);
          end
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev = {m_axis_tlast, m_axis_tdata};
        tick();
      end
    join
    m_axis_tready = 1'b1;
    repeat (6) tick();
    exp_q = '{{1'b0, 32'h700}, {1'b0, 32'h701}, {1'b1, 32'h702},
              {1'b0, 32'h710}, {1'b0, 32'h711}, {1'b1, 32'h712}};
    checks++;
    if (got.size() != 6) begin failures++; $display("FAIL b2b_count: got %0d expected 6", got.size()); end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_word%0d: got %h expected %h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_wrap();
    logic [W-1:0] d;
    do_reset();
    m_axis_tready = 1'b1;
    exp_q.delete();
    d = 32'h800;
    for (int p = 0; p < 14; p++) begin
      int len;
      len = (p % 5) + 1;
      for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1) ? 1'b1 : 1'b0, d + W'(i)});
      send_pkt(d, len);
      d = d + W'(len);
    end
    repeat (10) tick();
    checks++;
    if (got.size() != exp_q.size()) begin failures++; $display("FAIL wrap_count: got %0d expected %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin failures++; $display("FAIL wrap_word%0d: got %h expected %h", i, got[i], exp_q[i]); end
    end
    checks++;
    if (sts_level !== '0 || sts_drop !== 32'd0) begin
      failures++; $display("FAIL wrap_status: got level=%0d drop=%0d expected 0/0", sts_level, sts_drop);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_oversize();
    test_reset_mid();
    test_back_to_back();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_packet_buffer.md
Name: axis_packet_buffer

Overview:
- Store-and-forward AXI4-Stream packet FIFO placed directly downstream of the packetizer; consumes its tlast-framed packets.
- Forwards only complete packets, so the DMA/writer downstream never sees a partial frame.
- Input is never back-pressured. A packet that cannot fit is dropped whole and counted, so the ADC/DSP chain upstream never stalls.

Parameters:
- AXIS_TDATA_WIDTH, 32, data width of both stream ports.
- ADDR_WIDTH, 10, buffer address width; depth D = 2^ADDR_WIDTH words, usable capacity D-1 words.

Ports:
- aclk  in  1  clock
- areset  in  1  synchronous reset, active-high
- sts_drop  out  32  count of dropped packets, wraps modulo 2^32
- sts_level  out  ADDR_WIDTH  committed words currently stored
- s_axis_tready  out  1  constant 1 outside reset
- s_axis_tdata  in  AXIS_TDATA_WIDTH  input data
- s_axis_tvalid  in  1  input valid
- s_axis_tlast  in  1  input end of packet
- m_axis_tready  in  1  output ready
- m_axis_tdata  out  AXIS_TDATA_WIDTH  output data
- m_axis_tvalid  out  1  output valid
- m_axis_tlast  out  1  output end of packet

Behaviour:
- Storage: one RAM of D x (AXIS_TDATA_WIDTH+1) holding {tlast, tdata}, with a synchronous read port.
- Pointers, each ADDR_WIDTH bits and wrapping modulo D:
  - wr_ptr: tentative write pointer.
  - cm_ptr: committed pointer.
  - rd_ptr: read pointer.
- Input accept: a beat is accepted when s_axis_tvalid=1; s_axis_tready=0 only while areset=1.
- Input FSM states and transitions:
  - SYNC: initial state after reset. Discards beats until one with tlast=1 is accepted, then goes to PASS. This drops the tail of a packet that was in flight at reset; the tail is not counted in sts_drop.
  - PASS: full means wr_ptr+1 == rd_ptr.
    - Accepted beat and not full: write at wr_ptr, wr_ptr += 1. If tlast=1, cm_ptr <= wr_ptr+1 (commit).
    - Accepted beat and full: wr_ptr <= cm_ptr (rewind), sts_drop += 1. Go to DROP if tlast=0; stay in PASS if tlast=1.
  - DROP: discards beats until tlast=1 is accepted, then goes to PASS. No further sts_drop increment.
- A packet longer than D-1 words is always dropped; this is the required behaviour.
- Output: readable when rd_ptr != cm_ptr. A one-stage prefetch plus output register (first-word-fall-through) drives m_axis_*.
- Output holds tdata/tlast stable while m_axis_tvalid=1 and m_axis_tready=0.
- With m_axis_tready held at 1, the output sustains 1 word per cycle.
- Latency: when the buffer is empty and the final beat (tlast) is accepted at clock edge T, m_axis_tvalid rises after edge T+2 and the first word is presented.
- Simultaneous events:
  - Write, commit and read in the same cycle are all legal.
  - The full test uses rd_ptr registered before the edge. A read in the same cycle does not rescue the write; it is dropped (conservative).
  - Rewind and read in the same cycle are independent.
- sts_level = cm_ptr - rd_ptr (modulo D), registered; it counts words read into the prefetch stage as removed.
- Reset values: all pointers 0, FSM=SYNC, sts_drop=0, sts_level=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
- Reset mid-operation discards all buffered and in-flight data, including a word held on the output. This is a deliberate break of AXIS rules and is allowed only under reset.

Test Plan:
- Reset, send one 4-beat packet 0x10..0x13 (tlast on 0x13), m_axis_tready=1 -> nothing appears before the tlast beat is accepted. Output 0x10..0x13 starts 2 cycles after the tlast edge, tlast on 0x13; sts_drop=0.
- ADDR_WIDTH=4 (capacity 15), m_axis_tready=0, send packets of 10 and 8 beats -> first packet stored with sts_level=10. Second packet dropped, sts_drop=1. Raise tready -> exactly 10 words out, last one with tlast.
- ADDR_WIDTH=4, send one 20-beat packet -> dropped, sts_drop=1, sts_level=0, no output.
- Assert areset for 1 cycle mid-packet (beat 3 of 6), then continue the packet and send a new 2-beat packet -> remaining 3 beats discarded, only the 2-beat packet emerges, sts_drop=0.
- Back-to-back 3-beat packets at full rate, with m_axis_tready toggling 1,0,1,0 -> all 6 words in order, data stable during stalls, tlast on words 3 and 6, no loss.
- Stream packets continuously until the pointers wrap past D at least twice, with m_axis_tready=1 -> output sequence identical to input, sts_level returns to 0.
